regdump32: RTL and testbench

REGDUMP32 -- requirements
Module: regdump32

---
 rtl/regdump32_pkg.sv | 15 +
 rtl/regdump32.sv | 128 ++++++++++++
 tb/tb_regdump32.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regdump32_pkg.sv
// Shared state encoding and default geometry for the register dump streamer.
package regdump32_pkg;

  localparam int NREGS_DEF = 32;
  localparam int DW_DEF    = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_SEND = 3'd2,
    ST_CSUM = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/regdump32.sv
// Streams every register of a regfile read port out over a valid/ready link.
// Define REGDUMP_CSUM_EN to append an XOR checksum word to each dump.
module regdump32
  import regdump32_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic [4:0]    rdaddr,
  input  logic [DW-1:0] rddata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam int IW = $clog2(NREGS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREGS - 1);

  state_t          state_reg, state_next;
  logic [IW-1:0]   index_reg, index_next;
  logic [DW-1:0]   data_reg,  data_next;
  logic            last_reg,  last_next;
`ifdef REGDUMP_CSUM_EN
  logic [DW-1:0]   csum_reg,  csum_next;
`endif

  logic handshake;
  logic at_last;

  assign handshake = out_valid && out_ready;
  assign at_last   = (index_reg == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      index_reg <= '0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
`ifdef REGDUMP_CSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
`ifdef REGDUMP_CSUM_EN
      csum_reg  <= csum_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    data_next  = data_reg;
    last_next  = last_reg;
`ifdef REGDUMP_CSUM_EN
    csum_next  = csum_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          index_next = '0;
          last_next  = 1'b0;
`ifdef REGDUMP_CSUM_EN
          csum_next  = '0;
`endif
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        data_next  = rddata;
`ifdef REGDUMP_CSUM_EN
        csum_next  = csum_reg ^ rddata;
        last_next  = 1'b0;
`else
        last_next  = at_last;
`endif
        state_next = abort ? ST_FIN : ST_SEND;
      end
      ST_SEND: begin
        if (abort) begin
          state_next = ST_FIN;
        end else if (handshake) begin
          if (!at_last) begin
            index_next = index_reg + 1'b1;
            state_next = ST_READ;
          end else begin
`ifdef REGDUMP_CSUM_EN
            // Checksum already folds in every word latched in READ.
            data_next  = csum_reg;
            last_next  = 1'b1;
            state_next = ST_CSUM;
`else
            state_next = ST_FIN;
`endif
          end
        end
      end
      ST_CSUM: begin
        if (abort || handshake) state_next = ST_FIN;
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are pure decodes of registered state, so reset clears them all.
  assign out_valid = (state_reg == ST_SEND) || (state_reg == ST_CSUM);
  assign out_data  = data_reg;
  assign out_last  = last_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_FIN);
  assign rdaddr    = (state_reg == ST_IDLE) ? 5'd0 : 5'(index_reg);

endmodule

// File: tb/tb_regdump32.sv
// Self-checking bench for regdump32: randomized and directed dumps against a stream model.
module tb_regdump32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  rdaddr;
  logic [31:0] rddata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  int checks = 0;
  int failures = 0;

  // Observed stream and events, collected away from the active edge.
  logic [31:0] got_data [$];
  logic        got_last [$];
  int          cyc = 0;
  int          last_hs_cyc = -1;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          stable_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

`ifdef REGDUMP_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  regdump32 dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .rdaddr(rdaddr), .rddata(rddata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  assign rddata = regs[rdaddr];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        last_hs_cyc = cyc;
      end
      if (prev_stall && (!out_valid || out_data !== prev_data)) stable_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_obs();
    got_data.delete();
    got_last.delete();
    done_cnt   = 0;
    done_cyc   = -1;
    stable_err = 0;
    prev_stall = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({out_valid, out_last, busy, done} !== 4'b0000 || out_data !== 32'h0 || rdaddr !== 5'd0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%0b last=%0b busy=%0b done=%0b data=%h rdaddr=%0d, required all 0",
               out_valid, out_last, busy, done, out_data, rdaddr);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  // mode 0: ready always 1; 1: ready 1-0-0-1 pattern; 2: random ready
  task automatic test_dump(input string name, input int mode);
    logic [31:0] exp_q [$];
    logic [31:0] x;
    int k;
    x = '0;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(regs[i]);
      x ^= regs[i];
    end
    if (CSUM) exp_q.push_back(x);
    clear_obs();
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    k = 0;
    while (done_cnt == 0 && k < 2000) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (k % 4 == 0) || (k % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clock); #1;
      k++;
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL %s_done_count: got %0d, required 1", name, done_cnt);
    end
    checks++;
    if (got_data.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_word_count: got %0d, required %0d", name, got_data.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
          failures++;
          $display("FAIL %s_word%0d: got %h last=%0b, required %h last=%0b",
                   name, i, got_data[i], got_last[i], exp_q[i], (i == exp_q.size() - 1));
        end
      end
    end
    checks++;
    if (done_cyc != last_hs_cyc + 1) begin
      failures++;
      $display("FAIL %s_done_timing: done at cycle %0d, required %0d", name, done_cyc, last_hs_cyc + 1);
    end
    checks++;
    if (busy !== 1'b0 || rdaddr !== 5'd0) begin
      failures++;
      $display("FAIL %s_idle_after: busy=%0b rdaddr=%0d, required 0 and 0", name, busy, rdaddr);
    end
    checks++;
    if (stable_err != 0) begin
      failures++;
      $display("FAIL %s_stall_stable: %0d changes while stalled, required 0", name, stable_err);
    end
  endtask

  task automatic test_abort();
    int k;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    clear_obs();
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    k = 0;
    while (got_data.size() < 5 && k < 200) begin
      @(posedge clock); #1;
      k++;
    end
    out_ready = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clock); #1;
      k++;
    end
    checks++;
    if (!out_valid || rdaddr !== 5'd5) begin
      failures++;
      $display("FAIL abort_setup: valid=%0b rdaddr=%0d, required 1 and 5", out_valid, rdaddr);
    end
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_valid_drop: valid=%0b, required 0", out_valid);
    end
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (got_data.size() != 5 || done_cnt != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_result: words=%0d dones=%0d busy=%0b, required 5, 1, 0",
               got_data.size(), done_cnt, busy);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_data[i] !== regs[i]) begin
          failures++;
          $display("FAIL abort_word%0d: got %h, required %h", i, got_data[i], regs[i]);
        end
      end
    end
    out_ready = 1'b1;
    test_dump("restart_after_abort", 0);
  endtask

  task automatic test_reset_mid_dump();
    int k;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    clear_obs();
    start = 1'b1;
    out_ready = 1'b1;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!(busy && !out_valid && !done && rdaddr == 5'd10) && k < 200);
    reset = 1'b1;
    start = 1'b0;
    checks++;
    if (got_data.size() != 10) begin
      failures++;
      $display("FAIL start_held_words: got %0d words before index 10, required 10", got_data.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (got_data[i] !== regs[i]) begin
          failures++;
          $display("FAIL start_held_word%0d: got %h, required %h", i, got_data[i], regs[i]);
        end
      end
    end
    @(posedge clock); #1;
    checks++;
    if ({out_valid, out_last, busy, done} !== 4'b0000 || out_data !== 32'h0 || rdaddr !== 5'd0) begin
      failures++;
      $display("FAIL midreset_outputs: valid=%0b last=%0b busy=%0b done=%0b data=%h rdaddr=%0d, required all 0",
               out_valid, out_last, busy, done, out_data, rdaddr);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_no_done: dones=%0d busy=%0b, required 0 and 0", done_cnt, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h11111111;
    test_reset();
    test_dump("ordered_ready", 0);
    test_dump("ready_1001", 1);
    for (int i = 0; i < 32; i++) regs[i] = 32'h1 << i;
    test_dump("onehot_pattern", 0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      test_dump("random", 2);
    end
    test_abort();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
